// File: rtl/process_player_action.sv
// Validates a latched player action against the betting-round state and owns all
// chip accounting (stacks, pot, current bet, per-round contributions, fold flags).
module process_player_action #(
    parameter int unsigned NUM_PLAYERS    = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned STARTING_CHIPS = 50
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     accepted_input,
    input  logic [2:0]               accepted_players_input,
    input  logic [7:0]               accepted_players_money,
    input  logic [ID_W-1:0]          current_player,
    input  logic                     new_round,
    input  logic                     new_hand,
    input  logic                     award_pot,
    input  logic [ID_W-1:0]          winner_id,
    output logic                     busy,
    output logic                     action_done,
    output logic                     action_error,
    output logic [7:0]               pot,
    output logic [7:0]               current_bet,
    output logic [NUM_PLAYERS-1:0]   folded,
    output logic [8*NUM_PLAYERS-1:0] chips_bus
);

    localparam logic [2:0] ActFold  = 3'd0;
    localparam logic [2:0] ActCheck = 3'd1;
    localparam logic [2:0] ActCall  = 3'd2;
    localparam logic [2:0] ActRaise = 3'd3;
    localparam logic [2:0] ActAllIn = 3'd4;

    typedef enum logic [2:0] {StIdle, StValidate, StApply, StDone, StWaitRelease} state_e;

    state_e          state_q;
    logic            acc_prev_q;
    logic [2:0]      act_q;
    logic [7:0]      amt_q;
    logic [ID_W-1:0] seat_q;
    logic            legal_q;
    logic [7:0]      pay_q;
    logic [7:0]      bet_q;
    logic [7:0]      chips_q   [NUM_PLAYERS];
    logic [7:0]      contrib_q [NUM_PLAYERS];

    logic       seat_ok, folded_p, legal_c, ctrl;
    logic [7:0] chips_p, contrib_p, need, pay_c, bet_c;
    logic [8:0] raise_sum, allin_sum;

    assign ctrl = new_hand | new_round | award_pot;

    always_comb begin
        seat_ok   = 32'(seat_q) < NUM_PLAYERS;
        chips_p   = seat_ok ? chips_q[seat_q] : 8'd0;
        contrib_p = seat_ok ? contrib_q[seat_q] : 8'd0;
        folded_p  = seat_ok ? folded[seat_q] : 1'b1;
        need      = current_bet - contrib_p;
        // 9-bit sums so an oversized raise cannot wrap into a legal-looking value
        raise_sum = {1'b0, need} + {1'b0, amt_q};
        allin_sum = {1'b0, contrib_p} + {1'b0, chips_p};
        legal_c   = 1'b0;
        pay_c     = 8'd0;
        bet_c     = current_bet;
        if (!folded_p) begin
            case (act_q)
                ActFold:  legal_c = 1'b1;
                ActCheck: legal_c = (need == 8'd0);
                ActCall: begin
                    legal_c = (need != 8'd0) && (chips_p >= need);
                    pay_c   = need;
                end
                ActRaise: begin
                    legal_c = (amt_q != 8'd0) && (raise_sum <= {1'b0, chips_p});
                    pay_c   = raise_sum[7:0];
                    bet_c   = current_bet + amt_q;
                end
                ActAllIn: begin
                    legal_c = (chips_p != 8'd0);
                    pay_c   = chips_p;
                    if (allin_sum > {1'b0, current_bet}) bet_c = allin_sum[7:0];
                end
                default: legal_c = 1'b0;
            endcase
        end
    end

    always_comb begin
        chips_bus = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) chips_bus[8*k +: 8] = chips_q[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            acc_prev_q   <= 1'b0;
            act_q        <= 3'd0;
            amt_q        <= 8'd0;
            seat_q       <= '0;
            legal_q      <= 1'b0;
            pay_q        <= 8'd0;
            bet_q        <= 8'd0;
            busy         <= 1'b0;
            action_done  <= 1'b0;
            action_error <= 1'b0;
            pot          <= 8'd0;
            current_bet  <= 8'd0;
            folded       <= '0;
            for (int k = 0; k < NUM_PLAYERS; k++) begin
                chips_q[k]   <= 8'(STARTING_CHIPS);
                contrib_q[k] <= 8'd0;
            end
        end else begin
            acc_prev_q <= accepted_input;
            case (state_q)
                StIdle: begin
                    if (ctrl) begin
                        // Control wins; hold the edge detector so a coincident rise is not lost
                        acc_prev_q <= acc_prev_q;
                        if (new_hand || new_round) begin
                            current_bet <= 8'd0;
                            for (int k = 0; k < NUM_PLAYERS; k++) contrib_q[k] <= 8'd0;
                            if (new_hand) folded <= '0;
                        end else if (32'(winner_id) < NUM_PLAYERS) begin
                            chips_q[winner_id] <= chips_q[winner_id] + pot;
                            pot                <= 8'd0;
                        end
                    end else if (accepted_input && !acc_prev_q) begin
                        act_q   <= accepted_players_input;
                        amt_q   <= accepted_players_money;
                        seat_q  <= current_player;
                        busy    <= 1'b1;
                        state_q <= StValidate;
                    end
                end
                StValidate: begin
                    legal_q <= legal_c;
                    pay_q   <= pay_c;
                    bet_q   <= bet_c;
                    state_q <= StApply;
                end
                StApply: begin
                    if (legal_q) begin
                        chips_q[seat_q]   <= chips_q[seat_q] - pay_q;
                        contrib_q[seat_q] <= contrib_q[seat_q] + pay_q;
                        pot               <= pot + pay_q;
                        current_bet       <= bet_q;
                        if (act_q == ActFold) folded[seat_q] <= 1'b1;
                    end
                    action_done  <= 1'b1;
                    action_error <= !legal_q;
                    state_q      <= StDone;
                end
                StDone: begin
                    action_done  <= 1'b0;
                    action_error <= 1'b0;
                    if (accepted_input) begin
                        state_q <= StWaitRelease;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StWaitRelease: begin
                    if (!accepted_input) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
